// File: rtl/complex_dot_product_feeder_pkg.sv
// Shared types and constants for the complex dot-product row feeder.
package complex_dot_product_feeder_pkg;

  localparam int ELEMENT_WIDTH   = 64;
  localparam int NO_OF_UNITS     = 8;
  localparam int MIN_PACKAGE_GAP = 2;
  localparam int CLEAR_CYCLES    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_LOAD,
    ST_STROBE,
    ST_HOLD,
    ST_WAIT_FINISH
  } state_t;

  // Number of whole packages in an element count; any remainder is dropped.
  function automatic logic [31:0] packages_of(input logic [31:0] count,
                                              input int unsigned units);
    return count / units;
  endfunction

endpackage

// File: rtl/complex_feeder_addr_gen.sv
// Package index counter for the row feeder: holds the package count of the
// current run and flags the last package so the FSM knows when to stop fetching.
module complex_feeder_addr_gen
  import complex_dot_product_feeder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int no_of_units = NO_OF_UNITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              advance,
  input  logic [31:0]       total,
  output logic [ADDR_W-1:0] idx,
  output logic              empty,
  output logic              last
);

  logic [31:0] npk;

  assign empty = (packages_of(total, no_of_units) == 32'd0);

  // Compared in 32 bits so a full 2^ADDR_W run still terminates after the wrap.
  assign last = ((32'(idx) + 32'd1) == npk);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
      npk <= '0;
    end else if (load) begin
      idx <= '0;
      npk <= packages_of(total, no_of_units);
    end else if (clear) begin
      idx <= '0;
    end else if (advance) begin
      idx <= idx + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/complex_dot_product_feeder.sv
// Row-interface initiator for the conjugate-complex dot-product unit.
// Optional WAIT_FINISH watchdog: define COMPLEX_FEEDER_TIMEOUT_EN.
module complex_dot_product_feeder
  import complex_dot_product_feeder_pkg::*;
#(
  parameter int element_width  = ELEMENT_WIDTH,
  parameter int no_of_units    = NO_OF_UNITS,
  parameter int ADDR_W         = 10,
  parameter int PACKAGE_GAP    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [31:0]                        total,
  output logic                               busy,
  output logic                               done,
  output logic [element_width-1:0]           result,
  output logic                               rd_en,
  output logic [ADDR_W-1:0]                  rd_addr,
  input  logic [element_width*no_of_units-1:0] a_rd_data,
  input  logic [element_width*no_of_units-1:0] b_rd_data,
  output logic                               dp_reset,
  output logic [31:0]                        dp_total,
  output logic [element_width*no_of_units-1:0] first_row_output,
  output logic [element_width*no_of_units-1:0] second_row_output,
  output logic                               read_now,
  input  logic                               dp_finish,
  input  logic [element_width-1:0]           dp_result,
  output logic                               timeout
);

  localparam int CNT_W = $clog2(PACKAGE_GAP + 1);

  if (PACKAGE_GAP < MIN_PACKAGE_GAP || no_of_units < 2 || (no_of_units % 2) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("complex_dot_product_feeder: illegal parameter set");
  end

  state_t state, state_nx;
  logic [CNT_W-1:0] phase;
  logic accept, empty_run, load_rows, advance, capture, expire;
  logic empty, last;

  complex_feeder_addr_gen #(
    .ADDR_W      (ADDR_W),
    .no_of_units (no_of_units)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .clear   (capture | expire),
    .advance (advance),
    .total   (total),
    .idx     (rd_addr),
    .empty   (empty),
    .last    (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rd_en     = 1'b0;
    read_now  = 1'b0;
    dp_reset  = 1'b0;
    accept    = 1'b0;
    empty_run = 1'b0;
    load_rows = 1'b0;
    advance   = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (empty) empty_run = 1'b1;
          else       state_nx  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        dp_reset = 1'b1;
        if (phase == CNT_W'(CLEAR_CYCLES - 1)) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        rd_en    = 1'b1;
        state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        load_rows = 1'b1;
        state_nx  = ST_STROBE;
      end
      ST_STROBE: begin
        read_now = 1'b1;
        state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        if (phase == CNT_W'(PACKAGE_GAP - 1)) begin
          advance  = 1'b1;
          state_nx = last ? ST_WAIT_FINISH : ST_FETCH;
        end
      end
      ST_WAIT_FINISH: begin
        // Only looked at here, so a stale finish seen during CLEAR/FETCH is ignored.
        if (dp_finish) begin
          capture  = 1'b1;
          state_nx = ST_IDLE;
        end else if (expire) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Cycle counter shared by CLEAR and HOLD; restarts on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       phase <= '0;
    else if (state_nx != state)                       phase <= '0;
    else if (state == ST_CLEAR || state == ST_HOLD)   phase <= phase + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      dp_total <= '0;
    end else begin
      if (accept) begin
        dp_total <= total;
        busy     <= !empty_run;
        done     <= empty_run;
        if (empty_run) result <= '0;
      end
      if (capture) begin
        result <= dp_result;
        done   <= 1'b1;
        busy   <= 1'b0;
      end
      if (expire) begin
        result <= '0;
        done   <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

  // Rows change only on LOAD, so they stay stable through the strobe and HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_row_output  <= '0;
      second_row_output <= '0;
    end else if (load_rows) begin
      first_row_output  <= a_rd_data;
      second_row_output <= b_rd_data;
    end
  end

`ifdef COMPLEX_FEEDER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;

  assign expire = (state == ST_WAIT_FINISH) && !dp_finish &&
                  (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (state != ST_WAIT_FINISH) wait_cnt <= '0;
      else                         wait_cnt <= wait_cnt + TO_W'(1);
      if (accept)      timeout <= 1'b0;
      else if (expire) timeout <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_complex_dot_product_feeder.sv
// Scoreboard bench: two feeders (PACKAGE_GAP 2 and 4) share stimulus; a negedge
// monitor pops expected addresses, strobed rows and results as the DUTs present them.
module tb_complex_dot_product_feeder;

  localparam int EW = 64;
  localparam int NU = 8;
  localparam int AW = 10;
  localparam int RW = EW * NU;
  localparam int GAPS [2] = '{2, 4};

  typedef struct packed { logic [63:0] r; logic t; } res_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [31:0] total = '0;
  logic dp_finish = 1'b0;
  logic [63:0] dp_result = '0;

  logic busy [2], done [2], rd_en [2], dp_reset [2], read_now [2], timeout [2];
  logic [63:0] result [2];
  logic [AW-1:0] rd_addr [2];
  logic [31:0] dp_total [2];
  logic [RW-1:0] a_rd_data [2], b_rd_data [2], row_a [2], row_b [2];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int strb_cnt [2] = '{0, 0};
  int rst_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int last_strb [2] = '{0, 0};
  int hold_cnt [2] = '{0, 0};
  logic [RW-1:0] snap_a [2], snap_b [2];
  logic done_q [2] = '{1'b0, 1'b0};
  int exp_addr_q [2][$];
  int exp_strb_q [2][$];
  res_t exp_res_q [2][$];
  int mon_k;
  res_t mon_e;

  always #5 clk = ~clk;

  complex_dot_product_feeder #(.element_width(EW), .no_of_units(NU), .ADDR_W(AW),
    .PACKAGE_GAP(2), .TIMEOUT_CYCLES(16)) dut0 (
    .clk(clk), .reset(reset), .start(start), .total(total), .busy(busy[0]),
    .done(done[0]), .result(result[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
    .a_rd_data(a_rd_data[0]), .b_rd_data(b_rd_data[0]), .dp_reset(dp_reset[0]),
    .dp_total(dp_total[0]), .first_row_output(row_a[0]), .second_row_output(row_b[0]),
    .read_now(read_now[0]), .dp_finish(dp_finish), .dp_result(dp_result),
    .timeout(timeout[0]));

  complex_dot_product_feeder #(.element_width(EW), .no_of_units(NU), .ADDR_W(AW),
    .PACKAGE_GAP(4), .TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .reset(reset), .start(start), .total(total), .busy(busy[1]),
    .done(done[1]), .result(result[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
    .a_rd_data(a_rd_data[1]), .b_rd_data(b_rd_data[1]), .dp_reset(dp_reset[1]),
    .dp_total(dp_total[1]), .first_row_output(row_a[1]), .second_row_output(row_b[1]),
    .read_now(read_now[1]), .dp_finish(dp_finish), .dp_result(dp_result),
    .timeout(timeout[1]));

  function automatic logic [RW-1:0] pkg_data(input int k, input bit second);
    logic [RW-1:0] v;
    for (int i = 0; i < NU; i++)
      v[i*EW +: EW] = {(second ? 8'hB0 : 8'hA0), 8'(k), 8'(i), 8'h00,
                       32'(k * NU + i) ^ (second ? 32'h5555AAAA : 32'h0)};
    return v;
  endfunction

  function automatic void chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Synchronous-read vector memories, one pair per DUT.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_en[d]) begin
        a_rd_data[d] <= pkg_data(int'(rd_addr[d]), 1'b0);
        b_rd_data[d] <= pkg_data(int'(rd_addr[d]), 1'b1);
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        done_q[d]   = 1'b0;
        hold_cnt[d] = 0;
      end else begin
        if (rd_en[d]) begin
          if (exp_addr_q[d].size() == 0) chk($sformatf("dut%0d unexpected rd_en", d), rd_en[d], 0);
          else chk($sformatf("dut%0d rd_addr", d), rd_addr[d], exp_addr_q[d].pop_front());
        end
        if (dp_reset[d]) rst_cnt[d]++;
        if (hold_cnt[d] > 0) begin
          chk($sformatf("dut%0d row_a stable", d), row_a[d], snap_a[d]);
          chk($sformatf("dut%0d row_b stable", d), row_b[d], snap_b[d]);
          hold_cnt[d]--;
        end
        if (read_now[d]) begin
          strb_cnt[d]++;
          if (exp_strb_q[d].size() == 0) begin
            chk($sformatf("dut%0d unexpected read_now", d), read_now[d], 0);
          end else begin
            mon_k = exp_strb_q[d].pop_front();
            chk($sformatf("dut%0d row_a pkg%0d", d, mon_k), row_a[d], pkg_data(mon_k, 1'b0));
            chk($sformatf("dut%0d row_b pkg%0d", d, mon_k), row_b[d], pkg_data(mon_k, 1'b1));
            if (mon_k != 0)
              chk($sformatf("dut%0d strobe spacing", d), cyc - last_strb[d], 3 + GAPS[d]);
            last_strb[d] = cyc;
            snap_a[d]    = row_a[d];
            snap_b[d]    = row_b[d];
            hold_cnt[d]  = GAPS[d] + 2;
          end
        end
        if (done[d] && !done_q[d]) begin
          done_cnt[d]++;
          if (exp_res_q[d].size() != 0) begin
            mon_e = exp_res_q[d].pop_front();
            chk($sformatf("dut%0d result", d), result[d], mon_e.r);
            chk($sformatf("dut%0d timeout at done", d), timeout[d], mon_e.t);
          end
        end
        done_q[d] = done[d];
      end
    end
  end

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s dut%0d busy", tag, d), busy[d], 0);
      chk($sformatf("%s dut%0d done", tag, d), done[d], 0);
      chk($sformatf("%s dut%0d result", tag, d), result[d], 0);
      chk($sformatf("%s dut%0d rd_en", tag, d), rd_en[d], 0);
      chk($sformatf("%s dut%0d rd_addr", tag, d), rd_addr[d], 0);
      chk($sformatf("%s dut%0d dp_reset", tag, d), dp_reset[d], 0);
      chk($sformatf("%s dut%0d dp_total", tag, d), dp_total[d], 0);
      chk($sformatf("%s dut%0d row_a", tag, d), row_a[d], 0);
      chk($sformatf("%s dut%0d row_b", tag, d), row_b[d], 0);
      chk($sformatf("%s dut%0d read_now", tag, d), read_now[d], 0);
      chk($sformatf("%s dut%0d timeout", tag, d), timeout[d], 0);
    end
  endtask

  task automatic push_run(input int npk, input logic [63:0] rv, input bit to);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < npk; k++) begin
        exp_addr_q[d].push_back(k);
        exp_strb_q[d].push_back(k);
      end
      exp_res_q[d].push_back('{r: rv, t: to});
    end
  endtask

  task automatic wait_clear(input int base);
    for (int i = 0; i < 50 && rst_cnt[0] < base + 2; i++) @(posedge clk);
    @(negedge clk);
    dp_finish = 1'b0;
  endtask

  task automatic wait_done(input int b0, input int b1, input int budget);
    for (int i = 0; i < budget && (done_cnt[0] < b0 + 1 || done_cnt[1] < b1 + 1); i++)
      @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int tot, input logic [63:0] rv, input bit busy_poke);
    int npk;
    int b_s [2], b_r [2], b_d [2];
    npk = tot / NU;
    for (int d = 0; d < 2; d++) begin
      b_s[d] = strb_cnt[d]; b_r[d] = rst_cnt[d]; b_d[d] = done_cnt[d];
    end
    if (npk > 0) push_run(npk, rv, 1'b0);
    @(negedge clk);
    start = 1'b1;
    total = 32'(tot);
    @(negedge clk);
    start = 1'b0;
    total = 32'hFFFF_FFF0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("t%0d dut%0d busy after start", tot, d), busy[d], (npk > 0) ? 1 : 0);
      chk($sformatf("t%0d dut%0d done after start", tot, d), done[d], (npk > 0) ? 0 : 1);
      chk($sformatf("t%0d dut%0d timeout after start", tot, d), timeout[d], 0);
      chk($sformatf("t%0d dut%0d dp_total", tot, d), dp_total[d], tot);
      if (npk == 0) chk($sformatf("t%0d dut%0d zero result", tot, d), result[d], 0);
    end
    if (npk == 0) begin
      repeat (6) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("t%0d dut%0d dp_reset cycles", tot, d), rst_cnt[d] - b_r[d], 0);
        chk($sformatf("t%0d dut%0d strobes", tot, d), strb_cnt[d] - b_s[d], 0);
        chk($sformatf("t%0d dut%0d still done", tot, d), done[d], 1);
      end
      return;
    end
    wait_clear(b_r[0]);
    if (busy_poke) begin
      for (int i = 0; i < 100 && strb_cnt[0] < b_s[0] + 2; i++) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      total = 32'd80;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < npk * 10 + 50 && strb_cnt[0] < b_s[0] + npk; i++) @(posedge clk);
    repeat (3) @(negedge clk);
    dp_result = rv;
    dp_finish = 1'b1;
    wait_done(b_d[0], b_d[1], npk * 10 + 100);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("t%0d dut%0d completions", tot, d), done_cnt[d] - b_d[d], 1);
      chk($sformatf("t%0d dut%0d busy at end", tot, d), busy[d], 0);
      chk($sformatf("t%0d dut%0d done at end", tot, d), done[d], 1);
      chk($sformatf("t%0d dut%0d dp_total at end", tot, d), dp_total[d], tot);
      chk($sformatf("t%0d dut%0d dp_reset cycles", tot, d), rst_cnt[d] - b_r[d], 2);
      chk($sformatf("t%0d dut%0d strobes", tot, d), strb_cnt[d] - b_s[d], npk);
      chk($sformatf("t%0d dut%0d pending addr", tot, d), exp_addr_q[d].size(), 0);
      chk($sformatf("t%0d dut%0d pending result", tot, d), exp_res_q[d].size(), 0);
    end
  endtask

  task automatic reset_mid_hold();
    int b_s, b_r;
    b_s = strb_cnt[0];
    b_r = rst_cnt[0];
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) begin
        exp_addr_q[d].push_back(k);
        exp_strb_q[d].push_back(k);
      end
    @(negedge clk);
    start = 1'b1;
    total = 32'd64;
    @(negedge clk);
    start = 1'b0;
    wait_clear(b_r);
    for (int i = 0; i < 100 && strb_cnt[0] < b_s + 4; i++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("mid-hold idx", rd_addr[0], 3);
    chk("mid-hold busy", busy[0], 1);
    #1 reset = 1'b0;
    #1;
    check_zero("async reset");
    for (int d = 0; d < 2; d++) begin
      exp_addr_q[d].delete();
      exp_strb_q[d].delete();
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("post-reset dut%0d busy", d), busy[d], 0);
      chk($sformatf("post-reset dut%0d rd_addr", d), rd_addr[d], 0);
    end
  endtask

`ifdef COMPLEX_FEEDER_TIMEOUT_EN
  task automatic run_timeout();
    int b_r, b_d0, b_d1;
    b_r = rst_cnt[0]; b_d0 = done_cnt[0]; b_d1 = done_cnt[1];
    push_run(2, 64'h0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    total = 32'd16;
    @(negedge clk);
    start = 1'b0;
    wait_clear(b_r);
    wait_done(b_d0, b_d1, 400);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("timeout dut%0d completions", d), done_cnt[d] - ((d == 0) ? b_d0 : b_d1), 1);
      chk($sformatf("timeout dut%0d flag", d), timeout[d], 1);
      chk($sformatf("timeout dut%0d result", d), result[d], 0);
      chk($sformatf("timeout dut%0d busy", d), busy[d], 0);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset state");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run(32, 64'h0000000A_FFFFFFFE, 1'b0);
    run(7, 64'h0, 1'b0);
    run(24, 64'h12345678_9ABCDEF0, 1'b1);
    reset_mid_hold();
    run(16, 64'h00000001_00000002, 1'b0);
`ifdef COMPLEX_FEEDER_TIMEOUT_EN
    run_timeout();
    run(16, 64'h00000077_00000088, 1'b0);
`endif
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/complex_dot_product_feeder.md
Name: complex_dot_product_feeder

Overview:
- Initiator/producer side of the conjugate-complex dot-product unit's row interface.
- Fetches paired row packages (no_of_units complex elements each) from two synchronous-read vector memories.
- Presents them on the row buses with a one-cycle read_now strobe, then waits for the unit's finish and captures the scalar result.
- Sits between the vector RAMs and the dot-product datapath; controlled by the solver sequencer through start/done.

Parameters:
- element_width, 64: one complex element; upper half is real, lower half is imaginary.
- no_of_units, 8: elements per package; even, ≥2.
- ADDR_W, 10: package address width of the vector memories.
- PACKAGE_GAP, 2: HOLD cycles after each strobe; minimum 2, because the unit consumes the two halves on consecutive cycles.
- TIMEOUT_CYCLES, 4096: WAIT_FINISH watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  begin a dot product; sampled only in IDLE
- total  in  32  element count; packages = total/no_of_units, remainder ignored
- busy  out  1  high from start acceptance to completion
- done  out  1  level; high from completion until the next accepted start
- result  out  element_width  captured dot product
- rd_en  out  1  memory read enable
- rd_addr  out  ADDR_W  package index; shared by both memories
- a_rd_data  in  element_width*no_of_units  first-vector package, valid 1 cycle after rd_en
- b_rd_data  in  element_width*no_of_units  second-vector package, valid 1 cycle after rd_en
- dp_reset  out  1  active-high synchronous clear to the dot-product unit
- dp_total  out  32  latched total, driven to the unit
- first_row_output  out  element_width*no_of_units  row package A
- second_row_output  out  element_width*no_of_units  row package B
- read_now  out  1  one-cycle package strobe
- dp_finish  in  1  unit finish; a level once set
- dp_result  in  element_width  unit dot_product_output
- timeout  out  1  watchdog flag; tied 0 when the feature is compiled out

Behaviour:
- Reset values (reset=0): all outputs 0, state IDLE, package index 0.
- States: IDLE, CLEAR, FETCH, LOAD, STROBE, HOLD, WAIT_FINISH.
- IDLE:
  - On start=1: latch total into dp_total, compute npk = total/no_of_units, set busy=1, clear done.
  - If npk=0: result=0, done=1, busy=0, stay IDLE. No dp_reset and no strobe are issued.
  - Otherwise go to CLEAR.
- CLEAR: dp_reset=1 for exactly 2 cycles, which clears the unit's finish; then FETCH.
- FETCH: rd_en=1, rd_addr=idx for 1 cycle; then LOAD.
- LOAD: first_row_output<=a_rd_data and second_row_output<=b_rd_data; then STROBE.
- STROBE: read_now=1 for exactly 1 cycle; then HOLD.
- HOLD:
  - PACKAGE_GAP cycles.
  - Row outputs stay unchanged from LOAD until the next LOAD. This guarantees stability for at least the 2 cycles after the strobe.
  - On exit: idx<=idx+1. If idx+1==npk go to WAIT_FINISH, else FETCH.
- Package period: 3+PACKAGE_GAP cycles (5 at default). Strobe-to-strobe spacing equals the period.
- WAIT_FINISH:
  - dp_finish is ignored during CLEAR and the first cycle after it.
  - On dp_finish=1: result<=dp_result, done=1, busy=0, idx=0, go to IDLE.
- start is ignored while busy. start asserted in the same cycle done would set has no effect.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No partial result is retained.
- idx wraps modulo 2^ADDR_W. The caller guarantees npk ≤ 2^ADDR_W.

Optional Feature:
- Macro: COMPLEX_FEEDER_TIMEOUT_EN.
- With the macro:
  - A counter runs in WAIT_FINISH.
  - On reaching TIMEOUT_CYCLES without dp_finish: timeout=1, result=0, done=1, busy=0, go to IDLE.
  - timeout clears on the next accepted start.
- Without the macro: no counter; timeout is constant 0; WAIT_FINISH waits indefinitely.

Decomposition:
- Shared package holds:
  - state enum;
  - ELEMENT_WIDTH / NO_OF_UNITS defaults;
  - the minimum-PACKAGE_GAP constant;
  - the CLEAR length constant (2).
- One natural sub-module: complex_feeder_addr_gen.
  - Contains the package index counter, npk compare and last-package flag.
  - Control FSM, row registers and result capture stay in the top level.

Test Plan:
- Reset: reset=0 mid-HOLD with idx=3 -> all outputs 0 on the same edge; IDLE after release; a new start runs normally from idx 0.
- Basic run: total=32, no_of_units=8, PACKAGE_GAP=2 -> rd_addr sequence 0,1,2,3; read_now strobes 5 cycles apart; rows equal memory contents from LOAD onward; dp_finish with dp_result=64'h0000000A_FFFFFFFE -> result equal to that value, done=1.
- Zero length: total=7 -> done=1 and result=0 one cycle after start; no rd_en, no dp_reset, no read_now.
- Stale finish and busy start: dp_finish held 1 from a previous run -> not captured during CLEAR; a second start pulse during HOLD is ignored and rd_addr is unaffected.
- Gap parameter: PACKAGE_GAP=4, total=16 -> exactly 2 strobes 7 cycles apart; row outputs constant for 6 cycles after each strobe.
- Timeout (macro defined, TIMEOUT_CYCLES=16): dp_finish never asserted -> timeout=1, done=1, result=0 after 16 WAIT_FINISH cycles; the next start clears timeout.
